aim65_disp_ctrl: RTL
====================

// Module: aim65_disp_ctrl
// PURPOSE
//  Downstream consumer of the AIM-65 display PIA ports: decodes paOut/pbOut as a 5 x DL1416 (4-char) bus.
//  Latches characters into a 20-entry display buffer.
//  Exposes the buffer through a registered random-read port for the video renderer.
//  Emits a valid/ready update-event stream, buffered in a small FIFO, for mirrors (UART/debug).
// PARAMETERS
//  NUM_MODULES  5  DL1416 modules (1..5); buffer depth = 4*NUM_MODULES
//  FIFO_DEPTH   4  update-event FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1  system clock; everything is sampled on posedge
//  reset      in   1  synchronous, active-low reset
//  pa_in      in   8  PIA port A: [1:0] digit addr, [6:2] active-low module CE (bit 2 = module 0), [7] active-low /WR
//  pb_in      in   8  PIA port B: [6:0] ASCII char, [7] cursor-select (used only with AIM65_DISP_CURSOR_EN)
//  rd_addr    in   5  buffer read index (0 = leftmost char)
//  rd_data    out  7  char at rd_addr, 1-cycle latency
//  rd_cursor  out  1  cursor bit at rd_addr, 1-cycle latency (0 when feature off)
//  evt_valid  out  1  update event available
//  evt_ready  in   1  consumer accepts event
//  evt_addr   out  5  buffer index of event
//  evt_char   out  7  char written
//  evt_ovf    out  1  sticky: an event was dropped
//  ovf_clr    in   1  clears evt_ovf (1-cycle pulse)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): buffer all 7'h20, cursors 0, rd_data 7'h20, rd_cursor 0, FIFO empty, evt_valid 0, evt_addr/evt_char 0, evt_ovf 0, input regs = 8'hFF.
//  - pa_in/pb_in registered once (pa_q/pb_q); a write is the /WR rising edge: pa_q[7]==1 && wr_prev==0.
//  - Data/addr/CE are taken from pa_q/pb_q of the edge-detect cycle; buffer and FIFO update on the next posedge (2 clocks from pin to buffer).
//  - Index = 4*m + (3 - pa[1:0]) for each selected module m (DL1416 digit 0 is rightmost).
//  - Multiple CEs low: every selected module written. One event is pushed, carrying the lowest selected index.
//  - No CE low, or CE for m >= NUM_MODULES: write ignored, no event.
//  - /WR held low or high for many cycles: exactly one write per rising edge.
//  - Read port: rd_data/rd_cursor <= buf[rd_addr] each cycle. A write to the read index shows 1 cycle after the buffer update.
//  - rd_addr >= 4*NUM_MODULES returns 7'h20 / 0.
//  - Event FIFO: first-word-fall-through; evt_* stable while evt_valid && !evt_ready; pop on evt_valid && evt_ready.
//  - Full + push, no pop: event dropped, evt_ovf<=1. Full + push + pop same cycle: both happen, no overflow.
//  - Empty + push: evt_valid rises the cycle after the push.
//  - ovf_clr and a simultaneous overflow: evt_ovf stays 1 (set wins).
//  - Reset mid-operation: pending edge discarded, FIFO flushed, buffer re-blanked.
// CONFIGURATION
//  AIM65_DISP_CURSOR_EN defined:
//    - Write with pb[7]==1 is a cursor write: cursor[idx] <= pb[0]; char untouched; no event.
//    - rd_cursor is live.
//  AIM65_DISP_CURSOR_EN undefined:
//    - pb[7] ignored; every write is a char write.
//    - No cursor storage; rd_cursor tied 0.
// STRUCTURE
//  - Package aim65_disp_pkg:
//    - DISP_BLANK=7'h20, DIGITS_PER_MODULE=4, MAX_MODULES=5, disp_idx_t (5-bit).
//    - disp_evt_t struct {addr, char}.
//    - CE/WR bit-position constants.
//  - Sub-module aim65_disp_evt_fifo: sync FWFT FIFO of disp_evt_t, depth FIFO_DEPTH; full/empty outputs.
//  - Top holds input regs, edge detect, index decode, buffer, read mux, overflow flag.
// TESTING
//  - Reset then read idx 0..19 -> all 7'h20, evt_valid 0, evt_ovf 0.
//  - pb=8'h41, pa=8'b0_11110_00 then pa[7] 0->1 -> buf[3]=0x41 two clks later; event (3,0x41).
//  - pa CE=5'b11011 (module 2), addr 2'b11, pb=8'h5A -> buf[8]=0x5A; CE=5'b00000 write -> all 20 entries set, one event addr 0.
//  - evt_ready=0, 5 writes (FIFO_DEPTH=4) -> 4 events held, evt_ovf=1; drain -> order preserved; ovf_clr -> 0.
//  - FIFO full with evt_ready=1 and a write in the same cycle -> no overflow, count stays 4.
//  - CURSOR_EN: pb=8'h81 write to idx 5 -> rd_cursor=1 at idx 5, char unchanged, no event; macro off -> char 0x01 stored.

Source files
------------

// File: rtl/aim65_disp_pkg.sv
// rtl/aim65_disp_pkg.sv - shared types and constants for the AIM-65 display controller
package aim65_disp_pkg;

    localparam logic [6:0] DISP_BLANK        = 7'h20;
    localparam int         DIGITS_PER_MODULE = 4;
    localparam int         MAX_MODULES       = 5;

    // Bit positions on the PIA ports
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_MSB   = 1;
    localparam int CE_LSB     = 2;
    localparam int WR_BIT     = 7;
    localparam int CURSOR_BIT = 7;

    typedef logic [4:0] disp_idx_t;

    typedef struct packed {
        disp_idx_t  addr;
        logic [6:0] ch;
    } disp_evt_t;

endpackage

// File: rtl/aim65_disp_evt_fifo.sv
// rtl/aim65_disp_evt_fifo.sv - synchronous first-word-fall-through FIFO of display update events
module aim65_disp_evt_fifo
    import aim65_disp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  disp_evt_t wdata,
    input  logic      pop,
    output disp_evt_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    disp_evt_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aim65_disp_ctrl.sv
// rtl/aim65_disp_ctrl.sv - DL1416 bus decoder, display buffer, read port and update-event stream
// Optional cursor storage is enabled by defining AIM65_DISP_CURSOR_EN.
module aim65_disp_ctrl
    import aim65_disp_pkg::*;
#(
    parameter int NUM_MODULES = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    input  logic [4:0] rd_addr,
    output logic [6:0] rd_data,
    output logic       rd_cursor,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_addr,
    output logic [6:0] evt_char,
    output logic       evt_ovf,
    input  logic       ovf_clr
);

    localparam int DEPTH = DIGITS_PER_MODULE * NUM_MODULES;

    logic [7:0]             pa_q;
    logic [7:0]             pb_q;
    logic                   wr_prev;
    logic [NUM_MODULES-1:0] sel;
    disp_idx_t              first_idx;
    logic                   wr_hit;
    logic                   cur_wr;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    disp_evt_t              fifo_rdata;
    logic [6:0]             disp_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pa_q    <= 8'hFF;
            pb_q    <= 8'hFF;
            wr_prev <= 1'b1;
        end else begin
            pa_q    <= pa_in;
            pb_q    <= pb_in;
            wr_prev <= pa_q[WR_BIT];
        end
    end

    // Walk modules high to low so the lowest selected module sets the event index
    always_comb begin
        sel       = '0;
        first_idx = '0;
        for (int m = NUM_MODULES - 1; m >= 0; m--) begin
            sel[m] = ~pa_q[CE_LSB + m];
            if (sel[m]) begin
                first_idx = disp_idx_t'(DIGITS_PER_MODULE * m + 3 - int'(pa_q[ADDR_MSB:ADDR_LSB]));
            end
        end
    end

    assign wr_hit = pa_q[WR_BIT] && !wr_prev && (|sel);

`ifdef AIM65_DISP_CURSOR_EN
    assign cur_wr = pb_q[CURSOR_BIT];
`else
    logic unused_pb;
    assign unused_pb = pb_q[CURSOR_BIT];
    assign cur_wr    = 1'b0;
`endif

    assign push = wr_hit && !cur_wr;
    assign pop  = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                disp_mem[i] <= DISP_BLANK;
            end
        end else if (push) begin
            for (int m = 0; m < NUM_MODULES; m++) begin
                if (sel[m]) begin
                    disp_mem[DIGITS_PER_MODULE * m + 3 - int'(pa_q[ADDR_MSB:ADDR_LSB])] <= pb_q[6:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= DISP_BLANK;
        end else if (rd_addr < 5'(DEPTH)) begin
            rd_data <= disp_mem[rd_addr];
        end else begin
            rd_data <= DISP_BLANK;
        end
    end

`ifdef AIM65_DISP_CURSOR_EN
    logic cursor_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cursor_mem[i] <= 1'b0;
            end
        end else if (wr_hit && cur_wr) begin
            for (int m = 0; m < NUM_MODULES; m++) begin
                if (sel[m]) begin
                    cursor_mem[DIGITS_PER_MODULE * m + 3 - int'(pa_q[ADDR_MSB:ADDR_LSB])] <= pb_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cursor <= 1'b0;
        end else if (rd_addr < 5'(DEPTH)) begin
            rd_cursor <= cursor_mem[rd_addr];
        end else begin
            rd_cursor <= 1'b0;
        end
    end
`else
    assign rd_cursor = 1'b0;
`endif

    // Set beats clear: an overflow in the clearing cycle must not be lost
    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            evt_ovf <= 1'b1;
        end else if (ovf_clr) begin
            evt_ovf <= 1'b0;
        end
    end

    aim65_disp_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({first_idx, pb_q[6:0]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_addr  = fifo_rdata.addr;
    assign evt_char  = fifo_rdata.ch;

endmodule
